// File: rtl/time_setter.sv
// rtl/time_setter.sv - button conditioning, HH-MM-SS edit FSM and load strobe; optional TIME_SETTER_AUTOREPEAT_EN
module time_setter #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [3:0] h1,
    output logic [3:0] h0,
    output logic [3:0] m1,
    output logic [3:0] m0,
    output logic [3:0] s1,
    output logic [3:0] s0,
    output logic [2:0] cursor,
    output logic       edit_active,
    output logic       load_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int B_MODE = 0;
    localparam int B_UP   = 1;
    localparam int B_DOWN = 2;
    localparam int B_LEFT = 3;
    localparam int B_RIGHT = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EDIT   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  btn_raw;
    logic [4:0]  sync1_q, sync2_q;
    logic [4:0]  level;
    logic [4:0]  level_prev_q;
    logic [4:0]  edge_det;
    logic [4:0]  press;
    logic [4:0]  act;
    logic [3:0]  dig_q [6];
    logic [3:0]  dig_d [6];
    logic [2:0]  cursor_q, cursor_d;
    logic [3:0]  cur_max;

    assign btn_raw = {btn_right, btn_left, btn_down, btn_up, btn_mode};

    // Two-flop synchronizer for all raw buttons
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync2_q ^ sync2_q ^ sync1_q;
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_db
        logic [DB_W-1:0] cnt_q;
        logic            lvl_q;

        // Accept a new level only after it has been stable for DEBOUNCE_CYCLES samples
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else if (sync2_q[i] == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q <= '0;
                lvl_q <= sync2_q[i];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign level[i] = lvl_q;
    end

    // Previous accepted level, for rising-edge press detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_prev_q <= '0;
        end else begin
            level_prev_q <= level;
        end
    end

    assign edge_det = level & ~level_prev_q;

`ifdef TIME_SETTER_AUTOREPEAT_EN
    localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
    logic [1:0] rep_fire;

    for (genvar j = 0; j < 2; j++) begin : g_rep
        logic [RP_W-1:0] rep_cnt_q;

        // Up/down only: while held in EDIT, fire an extra press every REPEAT_CYCLES
        assign rep_fire[j] = (state_q == S_EDIT) && level[j+1] && !edge_det[j+1]
                             && (rep_cnt_q == RP_W'(REPEAT_CYCLES - 1));

        // Repeat interval counter, restarted by a fresh press, release or leaving EDIT
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rep_cnt_q <= '0;
            end else if ((state_q != S_EDIT) || !level[j+1] || edge_det[j+1] || rep_fire[j]) begin
                rep_cnt_q <= '0;
            end else begin
                rep_cnt_q <= rep_cnt_q + 1'b1;
            end
        end
    end

    assign press = edge_det | {2'b00, rep_fire, 1'b0};
`else
    assign press = edge_det;
`endif

    // Single winning action per cycle: mode > up > down > left > right
    always_comb begin
        act = '0;
        if (press[B_MODE])       act[B_MODE]  = 1'b1;
        else if (press[B_UP])    act[B_UP]    = 1'b1;
        else if (press[B_DOWN])  act[B_DOWN]  = 1'b1;
        else if (press[B_LEFT])  act[B_LEFT]  = 1'b1;
        else if (press[B_RIGHT]) act[B_RIGHT] = 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; COMMIT always lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (act[B_MODE]) state_d = S_EDIT;
            S_EDIT:   if (act[B_MODE]) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state
    always_comb begin
        edit_active = (state_q == S_EDIT);
        load_pulse  = (state_q == S_COMMIT);
    end

    function automatic logic [3:0] digit_max(input logic [2:0] idx, input logic [3:0] hi);
        case (idx)
            3'd0:       digit_max = 4'd2;
            3'd1:       digit_max = (hi == 4'd2) ? 4'd3 : 4'd9;
            3'd2, 3'd4: digit_max = 4'd5;
            default:    digit_max = 4'd9;
        endcase
    endfunction

    // Digit and cursor edits; the hour clamp keeps every held value a legal time
    always_comb begin
        dig_d    = dig_q;
        cursor_d = cursor_q;
        cur_max  = digit_max(cursor_q, dig_q[0]);
        if (state_q == S_IDLE) begin
            if (act[B_MODE]) cursor_d = 3'd0;
        end else if (state_q == S_EDIT) begin
            if (act[B_UP]) begin
                dig_d[cursor_q] = (dig_q[cursor_q] >= cur_max) ? 4'd0 : dig_q[cursor_q] + 4'd1;
            end else if (act[B_DOWN]) begin
                dig_d[cursor_q] = (dig_q[cursor_q] == 4'd0) ? cur_max : dig_q[cursor_q] - 4'd1;
            end else if (act[B_LEFT]) begin
                cursor_d = (cursor_q == 3'd0) ? 3'd5 : cursor_q - 3'd1;
            end else if (act[B_RIGHT]) begin
                cursor_d = (cursor_q >= 3'd5) ? 3'd0 : cursor_q + 3'd1;
            end
        end
        if ((dig_d[0] == 4'd2) && (dig_d[1] > 4'd3)) dig_d[1] = 4'd3;
    end

    // Digit and cursor registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 6; k++) dig_q[k] <= 4'd0;
            cursor_q <= 3'd0;
        end else begin
            dig_q    <= dig_d;
            cursor_q <= cursor_d;
        end
    end

    assign h1     = dig_q[0];
    assign h0     = dig_q[1];
    assign m1     = dig_q[2];
    assign m0     = dig_q[3];
    assign s1     = dig_q[4];
    assign s0     = dig_q[5];
    assign cursor = cursor_q;

endmodule

// File: tb/tb_time_setter.sv
// tb/tb_time_setter.sv - scoreboard bench for time_setter
module tb_time_setter;

    localparam int DB  = 4;
    localparam int RP  = 8;
    localparam int GAP = 2 + DB + 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btn;
    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic [2:0] cursor;
    logic       edit_active, load_pulse;

    int checks = 0;
    int errors = 0;
    int loads_seen = 0;
    logic [31:0] exp_q[$];
    logic [31:0] load_q[$];

    time_setter #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn[0]), .btn_up(btn[1]), .btn_down(btn[2]),
        .btn_left(btn[3]), .btn_right(btn[4]),
        .h1(h1), .h0(h0), .m1(m1), .m0(m0), .s1(s1), .s0(s0),
        .cursor(cursor), .edit_active(edit_active), .load_pulse(load_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [3:0] a, b, c, d, e, f,
                                         input logic [2:0] cur, input logic ed);
        pack = {4'h0, a, b, c, d, e, f, cur, ed};
    endfunction

    task automatic push_exp(input logic [3:0] a, b, c, d, e, f, input logic [2:0] cur, input logic ed);
        exp_q.push_back(pack(a, b, c, d, e, f, cur, ed));
    endtask

    task automatic compare_state(input string tag);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_noexp"}, 32'd1, 32'd0);
        end else begin
            check_eq(tag, pack(h1, h0, m1, m0, s1, s0, cursor, edit_active), exp_q.pop_front());
        end
    endtask

    task automatic pulse_btn(input logic [4:0] mask);
        btn = mask;
        repeat (GAP) @(posedge clk);
        #1 btn = 5'b0;
        repeat (GAP) @(posedge clk);
        #1;
    endtask

    // Load strobe monitor: every load must match a queued commit and last one cycle
    always @(negedge clk) begin
        if (reset && load_pulse) begin
            loads_seen++;
            if (load_q.size() == 0) begin
                check_eq("unexpected_load", 32'd1, 32'd0);
            end else begin
                check_eq("load_digits", {8'h0, h1, h0, m1, m0, s1, s0}, load_q.pop_front());
                check_eq("load_edit_low", {31'd0, edit_active}, 32'd0);
            end
        end
    end

    initial begin
        reset = 1'b0;
        btn   = 5'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_load", {31'd0, load_pulse}, 32'd0);
        push_exp(0, 0, 0, 0, 0, 0, 0, 0); compare_state("rst_state");
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        push_exp(0, 0, 0, 0, 0, 0, 0, 0); compare_state("idle_quiet");

        push_exp(0, 0, 0, 0, 0, 0, 0, 0); pulse_btn(5'b00010); compare_state("idle_up_ignored");
        push_exp(0, 0, 0, 0, 0, 0, 0, 1); pulse_btn(5'b00001); compare_state("enter_edit");

        push_exp(1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            btn[1] = (i % 2 == 0);
            repeat (2) @(posedge clk);
            #1;
        end
        btn[1] = 1'b1;
        repeat (10) @(posedge clk);
        #1 btn[1] = 1'b0;
        repeat (GAP) @(posedge clk);
        #1 compare_state("bounce_one_inc");

        push_exp(1, 0, 0, 0, 0, 0, 1, 1); pulse_btn(5'b10000); compare_state("right_c1");
        push_exp(1, 9, 0, 0, 0, 0, 1, 1); pulse_btn(5'b00100); compare_state("h0_down_wrap");
        push_exp(1, 9, 0, 0, 0, 0, 0, 1); pulse_btn(5'b01000); compare_state("left_c0");
        push_exp(2, 3, 0, 0, 0, 0, 0, 1); pulse_btn(5'b00010); compare_state("hour_clamp");
        push_exp(0, 3, 0, 0, 0, 0, 0, 1); pulse_btn(5'b00010); compare_state("h1_up_wrap");
        push_exp(0, 3, 0, 0, 0, 0, 5, 1); pulse_btn(5'b01000); compare_state("left_wrap_c5");
        push_exp(0, 3, 0, 0, 0, 9, 5, 1); pulse_btn(5'b00100); compare_state("s0_down_wrap");
        push_exp(0, 3, 0, 0, 0, 9, 0, 1); pulse_btn(5'b10000); compare_state("right_wrap_c0");
        push_exp(2, 3, 0, 0, 0, 9, 0, 1); pulse_btn(5'b00100); compare_state("h1_down_wrap");
        push_exp(2, 3, 0, 0, 0, 9, 1, 1); pulse_btn(5'b10000); compare_state("right_c1b");
        push_exp(2, 3, 0, 0, 0, 9, 2, 1); pulse_btn(5'b10000); compare_state("right_c2");
        push_exp(2, 3, 5, 0, 0, 9, 2, 1); pulse_btn(5'b00100); compare_state("m1_down_wrap");
        push_exp(2, 3, 5, 0, 0, 9, 3, 1); pulse_btn(5'b10000); compare_state("right_c3");
        push_exp(2, 3, 5, 9, 0, 9, 3, 1); pulse_btn(5'b00100); compare_state("m0_down_wrap");
        push_exp(2, 3, 5, 9, 0, 9, 4, 1); pulse_btn(5'b10000); compare_state("right_c4");
        push_exp(2, 3, 5, 9, 5, 9, 4, 1); pulse_btn(5'b00100); compare_state("s1_down_wrap");

        load_q.push_back({8'h0, 4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9});
        push_exp(2, 3, 5, 9, 5, 9, 4, 0); pulse_btn(5'b00001); compare_state("after_commit");
        check_eq("one_load", loads_seen, 32'd1);

        push_exp(2, 3, 5, 9, 5, 9, 0, 1); pulse_btn(5'b00001); compare_state("reenter_retained");
        push_exp(2, 3, 5, 9, 5, 9, 5, 1); pulse_btn(5'b01000); compare_state("left_c5");
        push_exp(2, 3, 5, 9, 5, 0, 5, 1); pulse_btn(5'b10010); compare_state("up_beats_right");
        push_exp(2, 3, 5, 9, 5, 0, 4, 1); pulse_btn(5'b01000); compare_state("left_c4");
        push_exp(2, 3, 5, 9, 5, 0, 3, 1); pulse_btn(5'b01000); compare_state("left_c3");
        push_exp(2, 3, 5, 0, 5, 0, 3, 1); pulse_btn(5'b00010); compare_state("m0_up_wrap");

        btn[1] = 1'b1;
        repeat (2 + DB + 40) @(posedge clk);
        #1 btn[1] = 1'b0;
        repeat (GAP) @(posedge clk);
        #1;
`ifdef TIME_SETTER_AUTOREPEAT_EN
        check_eq("hold_repeat_m0", {31'd0, (m0 >= 4'd4 && m0 <= 4'd6)}, 32'd1);
`else
        push_exp(2, 3, 5, 1, 5, 0, 3, 1); compare_state("hold_single_m0");
`endif

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        push_exp(0, 0, 0, 0, 0, 0, 0, 0); compare_state("reset_mid_edit");
        check_eq("no_extra_load", loads_seen, 32'd1);
        check_eq("load_q_drained", load_q.size(), 32'd0);
        check_eq("exp_q_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
